// File: rtl/sid_filter_mc_if.sv
// sid_filter_mc_if: control, per-channel parameter and audio bundle of the multi-channel SID filter
interface sid_filter_mc_if #(parameter int CHANNELS = 2, parameter int W = 16);
  logic                      start;
  logic                      clear_st;
  logic [CHANNELS*W-1:0]     vi;
  logic [CHANNELS*W-1:0]     vd;
  logic [CHANNELS*W-1:0]     w0;
  logic [CHANNELS*11-1:0]    res_q;
  logic [CHANNELS*3-1:0]     mode;
  logic [CHANNELS*4-1:0]     vol;
  logic                      busy;
  logic                      done;
  logic                      overrun;
  logic [CHANNELS*(W+4)-1:0] audio;
  modport master (output start, clear_st, vi, vd, w0, res_q, mode, vol,
                  input  busy, done, overrun, audio);
  modport slave  (input  start, clear_st, vi, vd, w0, res_q, mode, vol,
                  output busy, done, overrun, audio);
endinterface

// File: rtl/sid_filter_mc.sv
// sid_filter_mc: time-multiplexed multi-channel SID state-variable filter on one shared multiplier
module sid_filter_mc #(
  parameter int CHANNELS = 2,
  parameter int W        = 16,
  parameter int Q_FRAC   = 10
) (
  input logic           clk,
  input logic           rst,
  sid_filter_mc_if.slave bus
);
  localparam int PW = 2*W+4;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic signed [PW-1:0] SMAX = PW'((1 << (W-1)) - 1);
  localparam logic signed [PW-1:0] SMIN = -SMAX - 1;
  typedef enum logic [2:0] {IDLE, BP, LP, HP, MIX} state_t;
  state_t                    st_q;
  logic [CW-1:0]             ch_q;
  logic                      busy_q, done_q, ovr_q;
  logic [CHANNELS*W-1:0]     vi_q, vd_q, w0_q, vhp_q, vbp_q, vlp_q;
  logic [CHANNELS*11-1:0]    rq_q;
  logic [CHANNELS*3-1:0]     mode_q;
  logic [CHANNELS*4-1:0]     vol_q;
  logic [CHANNELS*(W+4)-1:0] audio_q;
  logic signed [W-1:0]       bp_q, lp_q, hp_q, bp_d, lp_d, hp_d, m;
  logic signed [W-1:0]       vi_c, vd_c, w0_c, vhp_c, vbp_c, vlp_c;
  logic [2:0]                mode_c;
  logic signed [W:0]         ma;
  logic signed [W-1:0]       mb;
  logic signed [2*W:0]       prod;
  logic signed [PW-1:0]      hsum, msum;
  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] x);
    return x > SMAX ? SMAX[W-1:0] : x < SMIN ? SMIN[W-1:0] : x[W-1:0];
  endfunction
  // one multiplier serves w0*state, res_q*vbp and vol*mix depending on the step
  always_comb begin
    vi_c   = vi_q[ch_q*W +: W];
    vd_c   = vd_q[ch_q*W +: W];
    w0_c   = w0_q[ch_q*W +: W];
    vhp_c  = vhp_q[ch_q*W +: W];
    vbp_c  = vbp_q[ch_q*W +: W];
    vlp_c  = vlp_q[ch_q*W +: W];
    mode_c = mode_q[ch_q*3 +: 3];
    hsum   = PW'(lp_q) + PW'(vi_c);
    msum   = PW'(vd_c) + (mode_c[0] ? PW'(lp_q) : '0) + (mode_c[1] ? PW'(bp_q) : '0)
           + (mode_c[2] ? PW'(hp_q) : '0);
    m      = sat(msum);
    ma     = st_q == HP  ? (W+1)'(rq_q[ch_q*11 +: 11]) :
             st_q == MIX ? (W+1)'(vol_q[ch_q*4 +: 4]) : (W+1)'(w0_c);
    mb     = st_q == BP ? vhp_c : st_q == LP ? vbp_c : st_q == HP ? bp_q : m;
    prod   = ma * mb;
    bp_d   = sat(PW'(vbp_c) - PW'(prod >>> 17));
    lp_d   = sat(PW'(vlp_c) - PW'(prod >>> 17));
    hp_d   = sat((PW'(prod) - (hsum <<< Q_FRAC)) >>> Q_FRAC);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      vi_q    <= '0;
      vd_q    <= '0;
      w0_q    <= '0;
      rq_q    <= '0;
      mode_q  <= '0;
      vol_q   <= '0;
      vhp_q   <= '0;
      vbp_q   <= '0;
      vlp_q   <= '0;
      bp_q    <= '0;
      lp_q    <= '0;
      hp_q    <= '0;
      audio_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start && busy_q) ovr_q <= 1'b1;
      case (st_q)
        IDLE: begin
          if (bus.clear_st) begin
            vhp_q <= '0;
            vbp_q <= '0;
            vlp_q <= '0;
          end
          if (bus.start) begin
            vi_q   <= bus.vi;
            vd_q   <= bus.vd;
            w0_q   <= bus.w0;
            rq_q   <= bus.res_q;
            mode_q <= bus.mode;
            vol_q  <= bus.vol;
            ch_q   <= '0;
            busy_q <= 1'b1;
            st_q   <= BP;
          end
        end
        BP: begin
          bp_q <= bp_d;
          st_q <= LP;
        end
        LP: begin
          lp_q <= lp_d;
          st_q <= HP;
        end
        HP: begin
          hp_q <= hp_d;
          st_q <= MIX;
        end
        default: begin
          vbp_q[ch_q*W +: W]         <= bp_q;
          vlp_q[ch_q*W +: W]         <= lp_q;
          vhp_q[ch_q*W +: W]         <= hp_q;
          audio_q[ch_q*(W+4) +: W+4] <= prod[W+3:0];
          if (ch_q == CW'(CHANNELS-1)) begin
            st_q   <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            ch_q <= ch_q + 1'b1;
            st_q <= BP;
          end
        end
      endcase
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;
  assign bus.audio   = audio_q;
endmodule
